// File: rtl/spi_regbank.sv
`default_nettype none
// ============================================================================
//  Module   : spi_regbank
//  Purpose  : SPI target (mode 0, MSB first) giving a host read/write access
//             to NUM_REGS control registers of DATA_W bits each.
//             Frame = 1 R/W bit (1 = write) + ADDR_W address + DATA_W data.
//  Ports    : clk, rst        system clock, synchronous active-high reset
//             sclk_i, ncs_i,  asynchronous SPI pins from the host
//             copi_i
//             cipo_o          read data to the host
//             cipo_oe_o       pad output enable, high while selected
//             regs_o          flat register image, reg i at [i*DATA_W +: DATA_W]
//             wr_strobe_o     one-clk pulse on a committed write
//             wr_addr_o       address of the last committed write
//             addr_err_o      one-clk pulse when a full frame hits an unmapped address
//  Revision : 1.0  initial release
// ============================================================================
module spi_regbank #(
  parameter int NUM_REGS = 5,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter logic [NUM_REGS*DATA_W-1:0] RST_VALS = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sclk_i,
  input  logic                         ncs_i,
  input  logic                         copi_i,
  output logic                         cipo_o,
  output logic                         cipo_oe_o,
  output logic [NUM_REGS*DATA_W-1:0]   regs_o,
  output logic                         wr_strobe_o,
  output logic [ADDR_W-1:0]            wr_addr_o,
  output logic                         addr_err_o
);

  localparam int C_FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int C_CNT_W   = $clog2(C_FRAME_W + 1);
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(C_FRAME_W - 1);
  localparam logic [C_CNT_W-1:0] C_CNT_HDR  = C_CNT_W'(ADDR_W);      // value before the last header bit
  localparam logic [C_CNT_W-1:0] C_CNT_RDY  = C_CNT_W'(1 + ADDR_W);  // header complete

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // --------------------------------------------------------------------------
  // Synchronisers: [0] metastability flop, [1] synchronised, [2] previous
  // --------------------------------------------------------------------------
  logic [2:0] sclk_s_q;
  logic [2:0] ncs_s_q;
  logic [1:0] copi_s_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_s_q <= 3'b000;
      ncs_s_q  <= 3'b111;
      copi_s_q <= 2'b00;
    end else begin
      sclk_s_q <= {sclk_s_q[1:0], sclk_i};
      ncs_s_q  <= {ncs_s_q[1:0], ncs_i};
      copi_s_q <= {copi_s_q[0], copi_i};
    end
  end

  logic w_sclk_rise, w_sclk_fall, w_ncs_fall, w_ncs_rise, w_copi;
  assign w_sclk_rise = sclk_s_q[1] & ~sclk_s_q[2];
  assign w_sclk_fall = ~sclk_s_q[1] & sclk_s_q[2];
  assign w_ncs_fall  = ~ncs_s_q[1] & ncs_s_q[2];
  assign w_ncs_rise  = ncs_s_q[1] & ~ncs_s_q[2];
  assign w_copi      = copi_s_q[1];

  // --------------------------------------------------------------------------
  // Frame FSM, bit counter and input shift register
  // --------------------------------------------------------------------------
  state_e                 state_q, state_d;
  logic [C_CNT_W-1:0]     cnt_q, cnt_d;
  logic [C_FRAME_W-1:0]   shreg_q, shreg_d;
  logic                   w_bit_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

  // A chip-select edge always outranks an sclk edge, so an ncs rise that
  // coincides with the final sclk rise aborts the frame.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    w_bit_taken = 1'b0;
    if (w_ncs_fall) begin
      state_d = ST_SHIFT;
      cnt_d   = '0;
      shreg_d = '0;
    end else if (w_ncs_rise) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_SHIFT && w_sclk_rise) begin
      shreg_d     = {shreg_q[C_FRAME_W-2:0], w_copi};
      cnt_d       = cnt_q + C_CNT_W'(1);
      w_bit_taken = 1'b1;
      if (cnt_q == C_CNT_LAST) begin
        state_d = ST_DONE;
      end
    end
  end

  assign cipo_oe_o = (state_q != ST_IDLE);

  // --------------------------------------------------------------------------
  // Register file
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] regs_q [NUM_REGS];

  // Full-frame fields; the shift register is stable in DONE
  logic              f_rw;
  logic [ADDR_W-1:0] f_addr;
  logic [DATA_W-1:0] f_data;
  logic              w_f_mapped;
  assign f_rw       = shreg_q[C_FRAME_W-1];
  assign f_addr     = shreg_q[C_FRAME_W-2 -: ADDR_W];
  assign f_data     = shreg_q[DATA_W-1:0];
  assign w_f_mapped = (32'(f_addr) < NUM_REGS);

  // Set on the cycle the counter reaches FRAME_W; the commit happens one clk later
  logic pend_q;
  logic w_commit_wr;
  assign w_commit_wr = pend_q & f_rw & w_f_mapped;

  logic wr_strobe_q, addr_err_q;
  logic [ADDR_W-1:0] wr_addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      addr_err_q  <= 1'b0;
      wr_addr_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RST_VALS[i*DATA_W +: DATA_W];
      end
    end else begin
      pend_q      <= (state_q == ST_SHIFT) && (state_d == ST_DONE);
      wr_strobe_q <= w_commit_wr;
      addr_err_q  <= pend_q & ~w_f_mapped;
      if (w_commit_wr) begin
        wr_addr_q <= f_addr;
      end
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_commit_wr && f_addr == ADDR_W'(i)) begin
          regs_q[i] <= f_data;
        end
      end
    end
  end

  assign wr_strobe_o = wr_strobe_q;
  assign addr_err_o  = addr_err_q;
  assign wr_addr_o   = wr_addr_q;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs_out
    assign regs_o[gi*DATA_W +: DATA_W] = regs_q[gi];
  end

  // --------------------------------------------------------------------------
  // Read path
  // --------------------------------------------------------------------------
  // Header as it will stand once the current bit is taken: {rw, addr}
  logic              w_hdr_rw;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_rd_load;
  assign w_hdr_rw  = shreg_d[ADDR_W];
  assign w_rd_addr = shreg_d[ADDR_W-1:0];
  assign w_rd_load = w_bit_taken && (cnt_q == C_CNT_HDR) && !w_hdr_rw;

  // Unmapped addresses fall through to zero
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_rd_addr == ADDR_W'(i)) begin
        w_rd_data = regs_q[i];
      end
    end
  end

  logic [DATA_W-1:0] dout_q;
  logic              rd_act_q;

  // The MSB appears right after the last header rise and must survive the
  // following fall so the host samples it on the first data rise; only the
  // falls after data bits have been clocked advance the shifter.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q   <= '0;
      rd_act_q <= 1'b0;
    end else if (w_ncs_fall || state_d == ST_IDLE) begin
      dout_q   <= '0;
      rd_act_q <= 1'b0;
    end else if (w_rd_load) begin
      dout_q   <= w_rd_data;
      rd_act_q <= 1'b1;
    end else if (rd_act_q && w_sclk_fall && cnt_q > C_CNT_RDY) begin
      dout_q   <= {dout_q[DATA_W-2:0], 1'b0};
    end
  end

  assign cipo_o = rd_act_q & dout_q[DATA_W-1];

endmodule
`default_nettype wire

// File: tb/tb_spi_regbank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_regbank
//  Purpose  : Self-checking bench for spi_regbank: directed frames followed by
//             random frames, checked against a register-array model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_regbank;

  localparam int NR   = 5;
  localparam int AW   = 7;
  localparam int DW   = 8;
  localparam int HALF = 8;   // sclk half period in clk cycles

  logic              clk = 1'b0;
  logic              rst;
  logic              sclk, ncs, copi;
  logic              cipo, cipo_oe, wr_strobe, addr_err;
  logic [NR*DW-1:0]  regs;
  logic [AW-1:0]     wr_addr;

  always #5 clk = ~clk;

  spi_regbank #(
    .NUM_REGS (NR),
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .RST_VALS (40'h0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sclk_i      (sclk),
    .ncs_i       (ncs),
    .copi_i      (copi),
    .cipo_o      (cipo),
    .cipo_oe_o   (cipo_oe),
    .regs_o      (regs),
    .wr_strobe_o (wr_strobe),
    .wr_addr_o   (wr_addr),
    .addr_err_o  (addr_err)
  );

  int n_vec  = 0;
  int n_fail = 0;

  // Pulse monitors, cleared by the driver before each frame
  int            strobe_cnt = 0;
  int            err_cnt    = 0;

  always @(negedge clk) begin
    if (wr_strobe === 1'b1) strobe_cnt++;
    if (addr_err  === 1'b1) err_cnt++;
  end

  // Reference model: register contents and last committed write address
  logic [DW-1:0] model [NR];
  logic [AW-1:0] last_wa;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) model[i] = '0;
    last_wa = '0;
  endtask

  // Host side of one frame. rst_at > 0 pulses rst after that many bits.
  task automatic spi_xfer(input logic [15:0] fr, input int nbits, input int rst_at,
                          output logic [7:0] rd);
    rd         = '0;
    strobe_cnt = 0;
    err_cnt    = 0;
    @(negedge clk);
    ncs = 1'b0;
    repeat (HALF) @(negedge clk);
    chk("cipo_oe_selected", 64'(cipo_oe), 64'd1);
    for (int i = 0; i < nbits; i++) begin
      copi = fr[15-i];
      repeat (HALF) @(negedge clk);
      if (i >= 8) rd[15-i] = cipo;
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
      if (i + 1 == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end
    repeat (HALF) @(negedge clk);
    ncs  = 1'b1;
    copi = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic check_state(input string tag, input int exp_st, input int exp_err);
    chk({tag, "_strobe_cnt"}, 64'(strobe_cnt), 64'(exp_st));
    chk({tag, "_err_cnt"},    64'(err_cnt),    64'(exp_err));
    chk({tag, "_wr_addr"},    64'(wr_addr),    64'(last_wa));
    chk({tag, "_cipo_oe_idle"}, 64'(cipo_oe),  64'd0);
    chk({tag, "_cipo_idle"},  64'(cipo),       64'd0);
    for (int i = 0; i < NR; i++) begin
      chk($sformatf("%s_reg%0d", tag, i), 64'(regs[i*DW +: DW]), 64'(model[i]));
    end
  endtask

  // Full frame through the model: decode, predict, drive, compare
  task automatic run_frame(input logic [15:0] fr, input int nbits, input string tag);
    logic [7:0]    rd;
    logic          rw;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] exp_rd;
    int            exp_st, exp_err;
    rw      = fr[15];
    a       = fr[14:8];
    d       = fr[7:0];
    exp_rd  = '0;
    exp_st  = 0;
    exp_err = 0;
    if (nbits == 16) begin
      if (int'(a) < NR) begin
        if (!rw) begin
          exp_rd = model[int'(a)];
        end else begin
          model[int'(a)] = d;
          last_wa        = a;
          exp_st         = 1;
        end
      end else begin
        exp_err = 1;
      end
    end
    spi_xfer(fr, nbits, 0, rd);
    if (nbits == 16) chk({tag, "_cipo_data"}, 64'(rd), 64'(exp_rd));
    check_state(tag, exp_st, exp_err);
  endtask

  initial begin
    logic [7:0]  rd;
    logic [15:0] fr;
    int          nb;

    rst  = 1'b1;
    sclk = 1'b0;
    ncs  = 1'b1;
    copi = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check_state("t1_reset", 0, 0);

    // Directed frames
    run_frame(16'h80F0, 16, "t2_wr_r0");
    run_frame(16'h8455, 16, "t3_wr_r4");
    run_frame(16'h0400, 16, "t3_rd_r4");
    run_frame(16'h90AA, 16, "t4_wr_unmapped");
    run_frame(16'h1000, 16, "t4_rd_unmapped");
    run_frame(16'h813C, 12, "t5_abort");
    run_frame(16'h813C, 16, "t5_full");
    run_frame(16'h0000, 16, "t3_rd_r0");

    // Reset in the middle of a write to reg 2
    run_frame(16'h8277, 16, "t6_prep");
    spi_xfer(16'h8299, 16, 9, rd);
    model_reset();
    check_state("t6_rst_mid", 0, 0);
    run_frame(16'h8211, 16, "t6_after");
    run_frame(16'h0200, 16, "t6_readback");

    // Random frames: mapped/unmapped, reads/writes, occasional aborts
    for (int k = 0; k < 24; k++) begin
      fr[15]   = 1'($urandom_range(0, 1));
      fr[14:8] = (k % 8 == 7) ? 7'h7F : 7'($urandom_range(0, 7));
      fr[7:0]  = 8'($urandom);
      nb       = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 15)) : 16;
      run_frame(fr, nb, $sformatf("rnd%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
